// File: rtl/vdp_pkg.sv
// vdp_pkg: shared constants for the VDP CPU port.
//   - Control second-byte field positions (register write, write setup).
//   - Status byte frame-flag position and the reg1 interrupt-enable bit.
//   - Default parameter values and the address-setup helper.
package vdp_pkg;

    localparam int unsigned CTRL_REG_BIT    = 7;  // 1xxx_rrrr: register write
    localparam int unsigned CTRL_WSETUP_BIT = 6;  // 01aa_aaaa: write setup, 00: read setup
    localparam int unsigned FRAME_BIT       = 7;  // frame flag position in status byte
    localparam int unsigned IRQ_EN_BIT      = 5;  // reg1 frame-interrupt enable
    localparam int unsigned DEF_NUM_REGS    = 8;
    localparam int unsigned DEF_VRAM_AW     = 14;
    localparam int unsigned SETUP_AW        = 14;

    // Full 14-bit setup address: six bits from the second byte above the latched first byte.
    function automatic logic [SETUP_AW-1:0] setup_addr(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[5:0], lo};
    endfunction

endpackage

// File: rtl/vdp_prefetch.sv
// vdp_prefetch: VRAM read-request handshake.
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : begin a prefetch at start_addr (only asserted while idle)
//   start_addr     : address to fetch
//   req, req_addr  : request and its address, held until ack
//   ack            : read complete
//   done           : one-cycle pulse in the ack cycle of an outstanding request
module vdp_prefetch
    import vdp_pkg::*;
#(
    parameter int unsigned VRAM_AW = DEF_VRAM_AW
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [VRAM_AW-1:0] start_addr,
    output logic               req,
    output logic [VRAM_AW-1:0] req_addr,
    input  logic               ack,
    output logic               done
);

    // An ack with no request outstanding (e.g. after reset) is ignored.
    assign done = req & ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req      <= 1'b0;
            req_addr <= '0;
        end else if (done) begin
            req <= 1'b0;
        end else if (start) begin
            req      <= 1'b1;
            req_addr <= start_addr;
        end
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: TMS9918-style CPU port (data/control port pair).
//   clk, reset_n             : clock, asynchronous active-low reset
//   cpu_wr, cpu_rd, cpu_mode : CPU strobes and port select (0 data, 1 control)
//   cpu_din, cpu_dout        : CPU write data, registered CPU read data
//   cpu_wait                 : high while a VRAM prefetch is outstanding
//   regs                     : flattened register file, reg n at [8n+7:8n]
//   vram_*                   : VRAM write pulse and read request/ack handshake
//   vblank, status_in        : end-of-frame pulse, live status bits 6:0
//   int_n                    : active-low frame interrupt
// Build option: define VDP_IRQ_EN to drive int_n from frame_flag and reg1 bit 5;
// otherwise int_n is tied high.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned VRAM_AW  = DEF_VRAM_AW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    input  logic                  cpu_mode,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_wait,
    output logic [NUM_REGS*8-1:0] regs,
    output logic [VRAM_AW-1:0]    vram_addr,
    output logic [7:0]            vram_wdata,
    output logic                  vram_we,
    output logic                  vram_rd_req,
    input  logic                  vram_rd_ack,
    input  logic [7:0]            vram_rdata,
    input  logic                  vblank,
    input  logic [6:0]            status_in,
    output logic                  int_n
);

    logic [7:0]          reg_file [NUM_REGS];
    logic [VRAM_AW-1:0]  addr, wr_addr, pf_addr, pf_start_addr;
    logic [7:0]          ctrl_latch, read_buf;
    logic                first_flag, frame_flag, frame_d;
    logic                pf_req, pf_done, pf_start;
    logic                wr_ok, rd_ok, reg_wr;
    logic [SETUP_AW-1:0] setup_full;
    logic [3:0]          reg_sel;

    // All CPU strobes are dropped while a prefetch is outstanding; write wins over read.
    assign cpu_wait    = pf_req;
    assign vram_rd_req = pf_req;
    assign wr_ok       = cpu_wr & ~pf_req;
    assign rd_ok       = cpu_rd & ~cpu_wr & ~pf_req;
    assign setup_full  = setup_addr(cpu_din, ctrl_latch);
    assign reg_sel     = cpu_din[3:0];
    assign reg_wr      = wr_ok & cpu_mode & first_flag & cpu_din[CTRL_REG_BIT];
    assign vram_addr   = pf_req ? pf_addr : wr_addr;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        assign regs[8*i +: 8] = reg_file[i];
    end

    always_comb begin
        pf_start      = 1'b0;
        pf_start_addr = addr;
        if (wr_ok && cpu_mode && first_flag && !cpu_din[CTRL_REG_BIT]
            && !cpu_din[CTRL_WSETUP_BIT]) begin
            pf_start      = 1'b1;
            pf_start_addr = setup_full[VRAM_AW-1:0];
        end else if (rd_ok && !cpu_mode) begin
            pf_start = 1'b1;
        end
    end

    // vblank has priority so a coincident status read leaves the flag set.
    always_comb begin
        frame_d = frame_flag;
        if (rd_ok && cpu_mode) frame_d = 1'b0;
        if (vblank) frame_d = 1'b1;
    end

    vdp_prefetch #(
        .VRAM_AW(VRAM_AW)
    ) u_prefetch (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (pf_start),
        .start_addr (pf_start_addr),
        .req        (pf_req),
        .req_addr   (pf_addr),
        .ack        (vram_rd_ack),
        .done       (pf_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= 8'h00;
            addr       <= '0;
            wr_addr    <= '0;
            ctrl_latch <= 8'h00;
            read_buf   <= 8'h00;
            first_flag <= 1'b0;
            frame_flag <= 1'b0;
            cpu_dout   <= 8'h00;
            vram_we    <= 1'b0;
            vram_wdata <= 8'h00;
        end else begin
            vram_we    <= 1'b0;
            frame_flag <= frame_d;
            if (pf_done) begin
                read_buf <= vram_rdata;
                addr     <= addr + VRAM_AW'(1);
            end
            if (wr_ok) begin
                if (cpu_mode) begin
                    if (!first_flag) begin
                        ctrl_latch <= cpu_din;
                        first_flag <= 1'b1;
                    end else begin
                        first_flag <= 1'b0;
                        if (cpu_din[CTRL_REG_BIT]) begin
                            // Register numbers beyond NUM_REGS match no entry and are dropped.
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (reg_sel == 4'(i)) reg_file[i] <= ctrl_latch;
                            end
                        end else begin
                            addr <= setup_full[VRAM_AW-1:0];
                        end
                    end
                end else begin
                    vram_we    <= 1'b1;
                    wr_addr    <= addr;
                    vram_wdata <= cpu_din;
                    read_buf   <= cpu_din;
                    addr       <= addr + VRAM_AW'(1);
                    first_flag <= 1'b0;
                end
            end else if (rd_ok) begin
                first_flag <= 1'b0;
                if (cpu_mode) begin
                    cpu_dout[FRAME_BIT]     <= frame_flag;
                    cpu_dout[FRAME_BIT-1:0] <= status_in;
                end else begin
                    cpu_dout <= read_buf;
                end
            end
        end
    end

`ifdef VDP_IRQ_EN
    logic [7:0] reg1_d;

    // Interrupt is computed from next-state values so it tracks frame_flag without lag.
    always_comb begin
        reg1_d = reg_file[1];
        if (reg_wr && reg_sel == 4'd1) reg1_d = ctrl_latch;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_n <= 1'b1;
        end else begin
            int_n <= ~(frame_d & reg1_d[IRQ_EN_BIT]);
        end
    end
`else
    assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port: scoreboard bench for vdp_cpu_port with a behavioural model,
// a VRAM responder with programmable ack delay, and a negedge monitor.
// Honours VDP_IRQ_EN for the expected int_n value.
`timescale 1ns/1ps
module tb_vdp_cpu_port;

    localparam int unsigned NR    = 8;
    localparam int unsigned AW    = 14;
    localparam int unsigned VSIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_mode = 1'b0;
    logic [7:0]    cpu_din = 8'h00;
    logic [7:0]    cpu_dout;
    logic          cpu_wait;
    logic [NR*8-1:0] regs;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_wdata;
    logic          vram_we, vram_rd_req;
    logic          vram_rd_ack = 1'b0;
    logic [7:0]    vram_rdata = 8'h00;
    logic          vblank = 1'b0;
    logic [6:0]    status_in = 7'h00;
    logic          int_n;

    always #5 clk = ~clk;

    vdp_cpu_port #(
        .NUM_REGS(NR),
        .VRAM_AW (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_mode   (cpu_mode),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_wait   (cpu_wait),
        .regs       (regs),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .vram_rd_req(vram_rd_req),
        .vram_rd_ack(vram_rd_ack),
        .vram_rdata (vram_rdata),
        .vblank     (vblank),
        .status_in  (status_in),
        .int_n      (int_n)
    );

    int total = 0;
    int bad   = 0;
    int ack_delay = 0;
    int we_count  = 0;

    // Behavioural model state.
    logic [7:0]    vmem   [VSIZE];
    logic [7:0]    m_regs [16];
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_latch = 8'h00, m_buf = 8'h00, m_dout = 8'h00;
    bit            m_first = 1'b0, m_frame = 1'b0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;
    wr_t           exp_wr   [$];
    logic [AW-1:0] exp_rd   [$];
    logic [7:0]    exp_dout [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Monitor: compares DUT-presented outputs against queued expectations.
    initial begin : monitor
        logic rd_pend;
        logic prev_req;
        wr_t  e;
        rd_pend  = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rd_pend) begin
                    if (exp_dout.size() == 0) fail_evt("dout_unexpected");
                    else check("cpu_dout", cpu_dout, exp_dout.pop_front());
                end
                rd_pend = cpu_rd && !cpu_wr && !cpu_wait;
                if (vram_we) begin
                    we_count++;
                    if (exp_wr.size() == 0) begin
                        fail_evt("vram_we_unexpected");
                    end else begin
                        e = exp_wr.pop_front();
                        check("we_addr", vram_addr, e.a);
                        check("we_data", vram_wdata, e.d);
                    end
                end
                if (vram_rd_req && !prev_req) begin
                    if (exp_rd.size() == 0) fail_evt("rd_req_unexpected");
                    else check("rd_addr", vram_addr, exp_rd.pop_front());
                end
                prev_req = vram_rd_req;
            end
        end
    end

    // VRAM responder: acks each request after ack_delay extra cycles.
    initial begin : responder
        forever begin
            @(negedge clk);
            if (vram_rd_req && reset_n) begin
                repeat (ack_delay) @(posedge clk);
                @(posedge clk);
                #1;
                vram_rd_ack = 1'b1;
                vram_rdata  = vmem[vram_addr];
                @(posedge clk);
                #1;
                vram_rd_ack = 1'b0;
                vram_rdata  = 8'($urandom);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cpu_wait && n < 100) begin
            tick();
            n++;
        end
        if (cpu_wait) fail_evt("wait_timeout");
    endtask

    task automatic strobe(input logic wr, input logic rd, input logic mode, input logic [7:0] d,
                          input logic vb);
        cpu_wr   = wr;
        cpu_rd   = rd;
        cpu_mode = mode;
        cpu_din  = d;
        vblank   = vb;
        tick();
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        vblank = 1'b0;
    endtask

    task automatic m_prefetch();
        exp_rd.push_back(m_addr);
        m_buf  = vmem[m_addr];
        m_addr = m_addr + 1'b1;
    endtask

    task automatic ctrl_write(input logic [7:0] b);
        wait_idle();
        if (!m_first) begin
            m_latch = b;
            m_first = 1'b1;
        end else begin
            m_first = 1'b0;
            if (b[7]) begin
                if (int'(b[3:0]) < NR) m_regs[b[3:0]] = m_latch;
            end else begin
                m_addr = AW'({b[5:0], m_latch});
                if (!b[6]) m_prefetch();
            end
        end
        strobe(1'b1, 1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic data_write(input logic [7:0] b, input logic also_rd);
        wait_idle();
        exp_wr.push_back('{a: m_addr, d: b});
        vmem[m_addr] = b;
        m_buf   = b;
        m_addr  = m_addr + 1'b1;
        m_first = 1'b0;
        strobe(1'b1, also_rd, 1'b0, b, 1'b0);
    endtask

    task automatic data_read();
        wait_idle();
        exp_dout.push_back(m_buf);
        m_dout  = m_buf;
        m_first = 1'b0;
        m_prefetch();
        strobe(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic ctrl_read(input logic vb);
        wait_idle();
        m_dout  = {m_frame, status_in};
        exp_dout.push_back(m_dout);
        m_first = 1'b0;
        m_frame = vb;
        strobe(1'b0, 1'b1, 1'b1, 8'h00, vb);
    endtask

    task automatic vblank_pulse();
        m_frame = 1'b1;
        strobe(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic check_state();
        logic exp_int;
        wait_idle();
        tick();
        tick();
        for (int i = 0; i < NR; i++) check("regs", regs[8*i +: 8], m_regs[i]);
`ifdef VDP_IRQ_EN
        exp_int = ~(m_frame & m_regs[1][5]);
`else
        exp_int = 1'b1;
`endif
        check("int_n", int_n, exp_int);
    endtask

    initial begin : main
        int we_before;
        int r;
        for (int i = 0; i < VSIZE; i++) vmem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_dout", cpu_dout, 8'h00);
        check("rst_we", vram_we, 1'b0);
        check("rst_req", vram_rd_req, 1'b0);
        check("rst_wait", cpu_wait, 1'b0);
        check("rst_int_n", int_n, 1'b1);
        check("rst_regs", regs, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Register write, then an out-of-range register write is dropped.
        ctrl_write(8'h5A);
        ctrl_write(8'h87);
        check_state();
        check("reg7_5a", regs[63:56], 8'h5A);
        ctrl_write(8'h11);
        ctrl_write(8'h8F);
        check_state();

        // Write setup at 0 then two sequential data writes; the read after shows addr=2.
        ctrl_write(8'h00);
        ctrl_write(8'h40);
        data_write(8'hAA, 1'b0);
        data_write(8'hBB, 1'b0);
        data_read();
        check_state();

        // Read setup at the top address wraps to 0 after the prefetch.
        vmem[14'h3FFF] = 8'h42;
        ctrl_write(8'hFF);
        ctrl_write(8'h3F);
        wait_idle();
        data_read();
        check("dout_42", cpu_dout, 8'h42);
        check_state();

        // Slow ack: wait stays high and strobes inside the interval are ignored.
        ack_delay = 5;
        data_read();
        we_before = we_count;
        for (int i = 0; i < 5; i++) begin
            check("wait_hold", cpu_wait, 1'b1);
            if (i == 1) strobe(1'b1, 1'b0, 1'b0, 8'h77, 1'b0);
            else if (i == 3) strobe(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
            else tick();
        end
        wait_idle();
        tick();
        check("no_we_in_wait", we_count, we_before);
        ack_delay = 0;
        data_read();
        check_state();

        // Frame interrupt and status read behaviour.
        ctrl_write(8'h20);
        ctrl_write(8'h81);
        check_state();
        vblank_pulse();
        check_state();
        ctrl_read(1'b0);
        check("status_b7", cpu_dout[7], 1'b1);
        check_state();
        vblank_pulse();
        ctrl_read(1'b1);
        ctrl_read(1'b0);
        check("status_b7_kept", cpu_dout[7], 1'b1);
        check_state();

        // Simultaneous write and read performs the write only.
        data_write(8'h3C, 1'b1);
        tick();
        check("wr_rd_dout", cpu_dout, m_dout);

        // Randomized mix against the model.
        for (int n = 0; n < 300; n++) begin
            ack_delay = $urandom_range(0, 3);
            status_in = 7'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: ctrl_write(8'($urandom));
                3, 4:    data_write(8'($urandom), 1'($urandom_range(0, 1)));
                5, 6:    data_read();
                7:       ctrl_read($urandom_range(0, 3) == 0);
                8:       vblank_pulse();
                default: check_state();
            endcase
        end
        check_state();
        repeat (4) tick();

        check("exp_wr_empty", exp_wr.size(), 0);
        check("exp_rd_empty", exp_rd.size(), 0);
        check("exp_dout_empty", exp_dout.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vdp_cpu_port.md
VDP_CPU_PORT -- requirements
Module: vdp_cpu_port

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of 8-bit VDP registers, 2..16.
REQ-002 SHALL have parameter VRAM_AW, default 14: VRAM address width, 12..14.
REQ-003 SHALL have port clk, input, 1: single clock for all state; CPU strobes are already synchronised to it.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port cpu_wr, input, 1: one-cycle CPU write strobe to the VDP port pair.
REQ-006 SHALL have port cpu_rd, input, 1: one-cycle CPU read strobe to the VDP port pair.
REQ-007 SHALL have port cpu_mode, input, 1: port select, 0=data, 1=control (CPU a[0]).
REQ-008 SHALL have port cpu_din, input, 8: CPU write data.
REQ-009 SHALL have port cpu_dout, output, 8: CPU read data, valid from the cycle after cpu_rd until the next cpu_rd.
REQ-010 SHALL have port cpu_wait, output, 1: high while a VRAM prefetch is outstanding.
REQ-011 SHALL have port regs, output, NUM_REGS*8: register file, flattened, reg n at [8n+7:8n].
REQ-012 SHALL have port vram_addr, output, VRAM_AW: VRAM access address.
REQ-013 SHALL have port vram_wdata, output, 8: VRAM write data.
REQ-014 SHALL have port vram_we, output, 1: one-cycle VRAM write pulse.
REQ-015 SHALL have port vram_rd_req, output, 1: read request, held until ack.
REQ-016 SHALL have port vram_rd_ack, input, 1: read complete; vram_rdata is valid in that cycle.
REQ-017 SHALL have port vram_rdata, input, 8: VRAM read data.
REQ-018 SHALL have port vblank, input, 1: one-cycle end-of-frame pulse.
REQ-019 SHALL have port status_in, input, 7: live status bits 6:0 (sprite flags and number).
REQ-020 SHALL have port int_n, output, 1: active-low interrupt.

Function
REQ-021 Control writes SHALL use a two-byte protocol: with first_flag=0, latch cpu_din and set first_flag; with first_flag=1, decode the second byte and clear first_flag.
REQ-022 Second byte 1xxx_rrrr SHALL write the latch to reg[rrrr] when rrrr<NUM_REGS; otherwise the write is dropped and first_flag is still cleared.
REQ-023 Second byte 01aa_aaaa SHALL set addr={aaaaaa,latch} truncated to VRAM_AW (write setup); no VRAM access.
REQ-024 Second byte 00aa_aaaa SHALL set addr the same way and start a prefetch at addr (read setup).
REQ-025 A prefetch SHALL raise vram_rd_req and vram_addr=addr the next cycle, hold both until vram_rd_ack, load read_buf from vram_rdata on ack, increment addr, and drop req the cycle after ack.
REQ-026 A data write SHALL pulse vram_we the next cycle with vram_addr=addr and vram_wdata=cpu_din, load read_buf with cpu_din, increment addr, and clear first_flag.
REQ-027 A data read SHALL return read_buf on cpu_dout, clear first_flag, and start a prefetch at the current addr.
REQ-028 addr increments SHALL wrap modulo 2^VRAM_AW (all-ones to 0).
REQ-029 A control read SHALL return {frame_flag,status_in}, clear frame_flag and first_flag.
REQ-030 vblank SHALL set frame_flag; when vblank and a control read coincide, the read returns the old value and frame_flag ends set.
REQ-031 cpu_wait SHALL equal vram_rd_req; cpu_wr and cpu_rd arriving while cpu_wait=1 SHALL be ignored entirely.
REQ-032 cpu_wr and cpu_rd in the same cycle SHALL perform the write only.

Reset
REQ-033 Reset SHALL clear regs, addr, latch, read_buf, first_flag, frame_flag, cpu_dout, vram_we and vram_rd_req to 0, and set int_n=1; an outstanding prefetch is abandoned and a late ack is ignored.

Configuration
REQ-034 With VDP_IRQ_EN defined, int_n SHALL be ~(frame_flag & reg1[5]), registered; without it, int_n SHALL be constant 1 while frame_flag remains readable.

Structure
REQ-035 Package vdp_pkg SHALL hold the control-byte field positions (bit7 reg-write, bit6 write-setup), the status bit index FRAME_BIT=7, and default parameter values.
REQ-036 The prefetch handshake (REQ-025) SHALL be one sub-module, vdp_prefetch.

Verification
REQ-037 Control writes 0x5A, 0x87 -> regs[7]=0x5A, first_flag=0; control writes 0x11, 0x8F with NUM_REGS=8 -> regs unchanged.
REQ-038 Control 0x00,0x40, then data writes 0xAA,0xBB -> vram_we at addr 0x0000 and 0x0001, addr=0x0002.
REQ-039 Control 0xFF,0x3F (VRAM_AW=14) -> prefetch at 0x3FFF; ack with 0x42 -> addr=0x0000; data read returns 0x42 and prefetches 0x0000.
REQ-040 Delay ack by 5 cycles -> cpu_wait high for the whole interval, and a data write inside that interval produces no vram_we.
REQ-041 reg1=0x20, vblank pulse -> int_n=0; status read returns bit7=1 and int_n=1 next cycle; vblank coincident with read -> flag stays set (VDP_IRQ_EN defined and undefined).
